// File: rtl/multisim_poll_scheduler.sv
`default_nettype none
// multisim_poll_scheduler: round-robin grant of one shared DPI poll slot across
// NUM_CHANNELS channels, with per-channel exponential backoff after empty polls.
module multisim_poll_scheduler #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DELAY_ACTIVE   = 10,
  parameter int DELAY_INACTIVE = 1000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [NUM_CHANNELS-1:0]         ch_blocked,
  output logic                            poll_vld,
  output logic [$clog2(NUM_CHANNELS)-1:0] poll_ch,
  input  logic                            poll_rdy,
  input  logic                            poll_done,
  input  logic                            poll_hit,
  output logic                            busy,
  output logic [31:0]                     hit_cnt
);

  localparam int CH_W = $clog2(NUM_CHANNELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                 state, next_state;
  logic [CH_W-1:0]        last_grant;
  logic [CH_W-1:0]        sel;
  logic                   found;
  logic [CH_W:0]          idx;
  logic [NUM_CHANNELS-1:0] eligible;
  logic [CNT_WIDTH-1:0]   cur_delay [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]   timer     [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]   load_val;
  logic [CNT_WIDTH+1:0]   shifted;
  logic                   accept_done;

  assign accept_done = (state == WAIT) && poll_done;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = (timer[i] == '0) && !ch_blocked[i] &&
                    !((state != IDLE) && (poll_ch == CH_W'(i)));
    end
  end

  // Search starts one past the last accepted grant; idx is one bit wider so the wrap is a single subtract.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = {1'b0, last_grant} + (CH_W+1)'(k + 1);
      if (idx >= (CH_W+1)'(NUM_CHANNELS)) begin
        idx = idx - (CH_W+1)'(NUM_CHANNELS);
      end
      if (!found && eligible[idx[CH_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[CH_W-1:0];
      end
    end
  end

  // Shift is done two bits wide so large delays saturate instead of wrapping.
  always_comb begin
    shifted = {2'b00, cur_delay[poll_ch]} << 2;
    if (poll_hit) begin
      load_val = CNT_WIDTH'(DELAY_ACTIVE);
    end else if (cur_delay[poll_ch] == '0) begin
      load_val = CNT_WIDTH'(1);
    end else if (shifted > (CNT_WIDTH+2)'(DELAY_INACTIVE)) begin
      load_val = CNT_WIDTH'(DELAY_INACTIVE);
    end else begin
      load_val = shifted[CNT_WIDTH-1:0];
    end
  end

  always_comb begin
    next_state = state;
    poll_vld   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && found) next_state = GRANT;
      end
      GRANT: begin
        poll_vld = 1'b1;
        busy     = 1'b1;
        if (poll_rdy) next_state = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (poll_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      poll_ch    <= '0;
      last_grant <= CH_W'(NUM_CHANNELS - 1);
      hit_cnt    <= '0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && enable && found) poll_ch <= sel;
      if ((state == GRANT) && poll_rdy) last_grant <= poll_ch;
      if (accept_done && poll_hit) hit_cnt <= hit_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cur_delay[i] <= '0;
        timer[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (accept_done && (poll_ch == CH_W'(i))) begin
          cur_delay[i] <= load_val;
          timer[i]     <= load_val;
        end else if (timer[i] != '0) begin
          timer[i] <= timer[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multisim_poll_scheduler.sv
`default_nettype none
// tb_multisim_poll_scheduler: directed and randomized checks of the poll scheduler
// against a timeline-based reference model (ready-at cycle per channel).
module tb_multisim_poll_scheduler;

  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int DA   = 10;
  localparam int DI   = 1000;
  localparam int CNTW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [NCH-1:0] ch_blocked;
  logic           poll_vld;
  logic [CW-1:0]  poll_ch;
  logic           poll_rdy;
  logic           poll_done;
  logic           poll_hit;
  logic           busy;
  logic [31:0]    hit_cnt;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  // Reference model: 0 idle, 1 grant, 2 wait; a channel is eligible once cyc reaches m_ready.
  int          m_state;
  int          m_ch;
  int          m_last;
  logic [31:0] m_hit;
  int          m_delay [NCH];
  longint      m_ready [NCH];

  multisim_poll_scheduler #(
    .NUM_CHANNELS  (NCH),
    .DELAY_ACTIVE  (DA),
    .DELAY_INACTIVE(DI),
    .CNT_WIDTH     (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ch_blocked(ch_blocked),
    .poll_vld  (poll_vld),
    .poll_ch   (poll_ch),
    .poll_rdy  (poll_rdy),
    .poll_done (poll_done),
    .poll_hit  (poll_hit),
    .busy      (busy),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int backoff(input int d);
    if (d == 0) return 1;
    return (d * 4 > DI) ? DI : d * 4;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_ch    = 0;
    m_last  = NCH - 1;
    m_hit   = '0;
    for (int i = 0; i < NCH; i++) begin
      m_delay[i] = 0;
      m_ready[i] = 0;
    end
  endtask

  task automatic model_edge();
    int  c;
    int  d;
    bit  got;
    got = 0;
    case (m_state)
      0: if (enable) begin
        for (int k = 1; k <= NCH; k++) begin
          c = (m_last + k) % NCH;
          if (!got && m_ready[c] <= cyc && !ch_blocked[c]) begin
            got     = 1;
            m_ch    = c;
            m_state = 1;
          end
        end
      end
      1: if (poll_rdy) begin
        m_state = 2;
        m_last  = m_ch;
      end
      2: if (poll_done) begin
        d = poll_hit ? DA : backoff(m_delay[m_ch]);
        if (poll_hit) m_hit = m_hit + 32'd1;
        m_delay[m_ch] = d;
        m_ready[m_ch] = cyc + d + 1;
        m_state       = 0;
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [33+CW:0] dut_obs();
    return {busy, poll_vld, poll_ch, hit_cnt};
  endfunction

  function automatic logic [33+CW:0] mdl_obs();
    return {(m_state != 0), (m_state == 1), CW'(m_ch), m_hit};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    ch_blocked = '0;
    poll_rdy   = 1'b0;
    poll_done  = 1'b0;
    poll_hit   = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (poll_vld !== 1'b0) begin errors++; $display("FAIL reset_poll_vld got=%b exp=0", poll_vld); end
    checks++; if (poll_ch !== 2'd0) begin errors++; $display("FAIL reset_poll_ch got=%0d exp=0", poll_ch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hit_cnt !== 32'd0) begin errors++; $display("FAIL reset_hit_cnt got=%0d exp=0", hit_cnt); end
  endtask

  task automatic test_rr_order();
    int grants[$];
    int exp_order[5];
    bit prev;
    exp_order = '{0, 1, 2, 3, 0};
    prev = 0;
    do_reset();
    enable   = 1'b1;
    poll_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      step();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++;
        $display("FAIL rr_lockstep cyc=%0d got=%h exp=%h", cyc, dut_obs(), mdl_obs());
      end
      if (poll_vld && !prev) grants.push_back(int'(poll_ch));
      prev      = poll_vld;
      poll_done = (m_state == 2);
      poll_hit  = 1'b0;
    end
    poll_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (grants.size() <= i) begin
        errors++;
        $display("FAIL rr_order[%0d] got=none exp=%0d", i, exp_order[i]);
      end else if (grants[i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, grants[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_backoff();
    int exp_d[12];
    bit hits[12];
    int k;
    exp_d = '{1, 4, 16, 64, 256, 1000, 1000, 10, 40, 160, 640, 1000};
    hits  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    do_reset();
    enable     = 1'b1;
    ch_blocked = 4'b1110;
    poll_rdy   = 1'b1;
    step();
    checks++;
    if (poll_vld !== 1'b1 || poll_ch !== 2'd0) begin
      errors++;
      $display("FAIL first_grant got vld=%b ch=%0d exp vld=1 ch=0", poll_vld, poll_ch);
    end
    for (int j = 0; j < 12; j++) begin
      step();
      poll_done = 1'b1;
      poll_hit  = hits[j];
      step();
      poll_done = 1'b0;
      poll_hit  = 1'b0;
      k = 0;
      do begin
        step();
        k++;
      end while (!poll_vld && k < 2100);
      checks++;
      if (!poll_vld || k != exp_d[j] + 1) begin
        errors++;
        $display("FAIL backoff_gap[%0d] got=%0d exp=%0d", j, k, exp_d[j] + 1);
      end
    end
    checks++;
    if (hit_cnt !== 32'd1) begin errors++; $display("FAIL backoff_hit_cnt got=%0d exp=1", hit_cnt); end
  endtask

  task automatic test_blocked();
    int grants[$];
    int exp_order[5];
    bit prev;
    exp_order = '{0, 2, 3, 0, 1};
    prev = 0;
    do_reset();
    enable     = 1'b1;
    ch_blocked = 4'b0010;
    poll_rdy   = 1'b1;
    for (int t = 0; t < 60; t++) begin
      step();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++;
        $display("FAIL blocked_lockstep cyc=%0d got=%h exp=%h", cyc, dut_obs(), mdl_obs());
      end
      if (poll_vld && !prev) grants.push_back(int'(poll_ch));
      prev = poll_vld;
      if (grants.size() >= 4) ch_blocked = '0;
      poll_done = (m_state == 2);
      poll_hit  = 1'b0;
    end
    poll_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (grants.size() <= i) begin
        errors++;
        $display("FAIL blocked_order[%0d] got=none exp=%0d", i, exp_order[i]);
      end else if (grants[i] != exp_order[i]) begin
        errors++;
        $display("FAIL blocked_order[%0d] got=%0d exp=%0d", i, grants[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    enable   = 1'b1;
    poll_rdy = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      poll_done = (i == 1);
      poll_hit  = (i == 1);
      if (i == 2) enable = 1'b0;
      if (i == 3) ch_blocked = 4'b0001;
      step();
      checks++;
      if (poll_vld !== 1'b1 || poll_ch !== 2'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d] got vld=%b ch=%0d busy=%b exp vld=1 ch=0 busy=1", i, poll_vld, poll_ch, busy);
      end
    end
    poll_done = 1'b0;
    poll_hit  = 1'b0;
    poll_rdy  = 1'b1;
    step();
    poll_rdy  = 1'b0;
    poll_done = 1'b1;
    step();
    poll_done = 1'b0;
    checks++;
    if (hit_cnt !== 32'd0 || busy !== 1'b0 || poll_vld !== 1'b0) begin
      errors++;
      $display("FAIL stall_after got hit=%0d busy=%b vld=%b exp hit=0 busy=0 vld=0", hit_cnt, busy, poll_vld);
    end
    enable     = 1'b1;
    ch_blocked = '0;
    poll_rdy   = 1'b1;
    for (int t = 0; t < 12; t++) begin
      step();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++;
        $display("FAIL stall_lockstep cyc=%0d got=%h exp=%h", cyc, dut_obs(), mdl_obs());
      end
      poll_done = (m_state == 2);
    end
    poll_done = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    enable   = 1'b1;
    poll_rdy = 1'b1;
    step();
    step();
    poll_done = 1'b1;
    poll_hit  = 1'b1;
    step();
    poll_done = 1'b0;
    poll_hit  = 1'b0;
    checks++;
    if (hit_cnt !== 32'd1) begin errors++; $display("FAIL riw_hit_before got=%0d exp=1", hit_cnt); end
    step();
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || poll_vld !== 1'b0 || hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL riw_async got busy=%b vld=%b hit=%0d exp busy=0 vld=0 hit=0", busy, poll_vld, hit_cnt);
    end
    step();
    rst       = 1'b0;
    enable    = 1'b0;
    poll_done = 1'b1;
    poll_hit  = 1'b1;
    step();
    poll_done = 1'b0;
    poll_hit  = 1'b0;
    checks++;
    if (hit_cnt !== 32'd0 || busy !== 1'b0 || poll_vld !== 1'b0) begin
      errors++;
      $display("FAIL riw_done_ignored got busy=%b vld=%b hit=%0d exp busy=0 vld=0 hit=0", busy, poll_vld, hit_cnt);
    end
    enable = 1'b1;
    step();
    checks++;
    if (poll_vld !== 1'b1 || poll_ch !== 2'd0) begin
      errors++;
      $display("FAIL riw_regrant got vld=%b ch=%0d exp vld=1 ch=0", poll_vld, poll_ch);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      step();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++;
        $display("FAIL random_lockstep cyc=%0d got=%h exp=%h", cyc, dut_obs(), mdl_obs());
      end
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) ch_blocked = 4'($urandom_range(0, 15));
      poll_rdy  = ($urandom_range(0, 1) == 1);
      poll_done = (m_state == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      poll_hit  = ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    ch_blocked = '0;
    poll_rdy   = 1'b0;
    poll_done  = 1'b0;
    poll_hit   = 1'b0;
    test_reset();
    test_rr_order();
    test_backoff();
    test_blocked();
    test_stall();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multisim_poll_scheduler.md
MULTISIM_POLL_SCHEDULER -- requirements
Module: multisim_poll_scheduler

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, number of server channels sharing one DPI poll slot (2..16).
REQ-002 Parameter DELAY_ACTIVE, default 10, reload delay in cycles after a poll that returned data.
REQ-003 Parameter DELAY_INACTIVE, default 1000, backoff ceiling in cycles after a poll that returned no data.
REQ-004 Parameter CNT_WIDTH, default 16, width of the per-channel delay and timer registers; SHALL hold DELAY_INACTIVE.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  when low, no new grant is issued.
REQ-008 ch_blocked  input  NUM_CHANNELS  bit i high: channel i downstream not ready, not eligible.
REQ-009 poll_vld  output  1  grant valid: execute a DPI poll for channel poll_ch.
REQ-010 poll_ch  output  $clog2(NUM_CHANNELS)  granted channel index.
REQ-011 poll_rdy  input  1  poll executor accepts the grant.
REQ-012 poll_done  input  1  one-cycle pulse: granted poll finished.
REQ-013 poll_hit  input  1  qualifies poll_done: the poll returned data.
REQ-014 busy  output  1  high in GRANT or WAIT.
REQ-015 hit_cnt  output  32  count of poll_done pulses with poll_hit high; wraps modulo 2^32.

Function
REQ-016 Per channel i: registers cur_delay[i] and timer[i], both CNT_WIDTH bits.
REQ-017 Every cycle, each nonzero timer[i] decrements by 1; a zero timer holds at 0; this applies to all channels, including the channel in flight.
REQ-018 Channel i is eligible when timer[i]==0, ch_blocked[i]==0, and i is not the channel in flight.
REQ-019 FSM states: IDLE, GRANT, WAIT.
REQ-020 IDLE: if enable and any channel is eligible, select one by round-robin starting at last_grant+1 (mod NUM_CHANNELS), register poll_ch, go to GRANT; otherwise stay in IDLE.
REQ-021 GRANT: poll_vld=1 and poll_ch is held stable; on poll_rdy, go to WAIT and set last_grant=poll_ch; poll_vld=0 from the next cycle.
REQ-022 WAIT: on poll_done, go to IDLE and load the granted channel: if poll_hit, cur_delay=timer=DELAY_ACTIVE; else cur_delay=timer=backoff(cur_delay).
REQ-023 backoff(d) = 1 if d==0, else min(d<<2, DELAY_INACTIVE); the shift SHALL be evaluated at CNT_WIDTH+2 bits so no overflow occurs before saturation.
REQ-024 poll_done outside WAIT is ignored; poll_hit is ignored without poll_done.
REQ-025 Timing: with no contention and enable high, the next poll_vld for a channel loaded with D rises exactly D+1 cycles after the edge that sampled poll_done.
REQ-026 enable low in GRANT or WAIT does not abort the transaction; it only blocks the IDLE->GRANT transition.
REQ-027 ch_blocked rising during GRANT does not withdraw the grant.
REQ-028 A channel blocked while its timer is 0 keeps timer 0 and is granted on the first IDLE cycle after it unblocks, subject to round-robin.
REQ-029 busy=1 in GRANT and WAIT, 0 in IDLE.
REQ-030 hit_cnt increments by 1 on each accepted poll_done with poll_hit high.

Reset
REQ-031 While rst is high: state=IDLE, poll_vld=0, poll_ch=0, busy=0, hit_cnt=0, last_grant=NUM_CHANNELS-1, all cur_delay=0, all timer=0.
REQ-032 Reset asserted mid-transaction abandons the transaction; a later poll_done is ignored unless the FSM is in WAIT.
REQ-033 The first grant after reset release is channel 0, provided it is eligible and enable is high.

Verification
REQ-034 Reset release, enable=1, ch_blocked=0, N=4 -> grants in order 0,1,2,3 (poll_rdy tied 1, poll_done 1 cycle later, poll_hit=0); each channel then reloads timer=1.
REQ-035 Single channel, poll_hit always 0 -> successive loaded delays 1,4,16,64,256,1000,1000; grant spacing after poll_done = delay+1.
REQ-036 Channel at delay 1000, then poll_hit=1 -> delay 10; following misses -> 40,160,640,1000.
REQ-037 ch_blocked[1]=1 with all timers 0 -> grants cycle 0,2,3,0; clearing ch_blocked[1] -> channel 1 is granted in its round-robin slot.
REQ-038 poll_rdy held 0 for 5 cycles -> poll_vld and poll_ch stable for 5 cycles; poll_done pulsed during GRANT -> ignored, no timer load.
REQ-039 rst pulsed while in WAIT, then poll_done -> no load, hit_cnt=0, poll_vld=0 and state IDLE.
